// File: rtl/pipeline_stall_ctrl.sv
// rtl/pipeline_stall_ctrl.sv - pipeline hazard/stall/flush controller with stall watchdog
// Optional perf counters (lu_stall_cnt, mem_stall_cnt) enabled by defining STALL_PERF_CNT_EN.
module pipeline_stall_ctrl #(
  parameter int unsigned FLUSH_CYCLES  = 1,
  parameter int unsigned STALL_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hz_load_use,
  input  logic        branch_taken,
  input  logic        dmem_busy,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic        ex_mem_en,
  output logic [1:0]  ctrl_state,
  output logic        timeout
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [31:0] lu_stall_cnt,
  output logic [31:0] mem_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2,
    ILLEGAL  = 2'd3
  } state_t;

  localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [7:0] STALL_LIMIT  = 8'(STALL_TIMEOUT);
  localparam bit         MULTI_FLUSH  = (FLUSH_CYCLES > 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] flush_cnt;
  logic [3:0] flush_cnt_nxt;
  logic [7:0] stall_cnt;
  logic       lu_act;
  logic       mem_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      flush_cnt <= 4'd0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
    end
  end

  // Priority is dmem_busy > branch_taken > hz_load_use regardless of state;
  // MEM_WAIT and the unused encoding decide exactly like RUN once memory is ready.
  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    ex_mem_en     = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    lu_act        = 1'b0;
    mem_hold      = 1'b0;

    if (dmem_busy) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_hold  = 1'b1;
      state_nxt = (state == FLUSH) ? FLUSH : MEM_WAIT;
    end else if (branch_taken) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      if (MULTI_FLUSH) begin
        state_nxt     = FLUSH;
        flush_cnt_nxt = FLUSH_RELOAD;
      end else begin
        state_nxt     = RUN;
        flush_cnt_nxt = 4'd0;
      end
    end else if (state == FLUSH) begin
      if_id_flush   = 1'b1;
      id_ex_bubble  = 1'b1;
      flush_cnt_nxt = (flush_cnt == 4'd0) ? 4'd0 : flush_cnt - 4'd1;
      state_nxt     = (flush_cnt <= 4'd1) ? RUN : FLUSH;
    end else if (hz_load_use) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_bubble = 1'b1;
      lu_act       = 1'b1;
      state_nxt    = RUN;
    end else begin
      state_nxt = RUN;
    end

    if (!rst_n) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      ex_mem_en    = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      lu_act       = 1'b0;
      mem_hold     = 1'b0;
    end
  end

  assign ctrl_state = state;

  // Watchdog only observes pc_en; it never feeds back into pipeline control.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= 8'd0;
      timeout   <= 1'b0;
    end else if (!pc_en) begin
      if (stall_cnt < STALL_LIMIT) begin
        stall_cnt <= stall_cnt + 8'd1;
      end
      if (({1'b0, stall_cnt} + 9'd1) >= {1'b0, STALL_LIMIT}) begin
        timeout <= 1'b1;
      end
    end else begin
      stall_cnt <= 8'd0;
    end
  end

`ifdef STALL_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lu_stall_cnt  <= 32'd0;
      mem_stall_cnt <= 32'd0;
    end else begin
      if (lu_act) begin
        lu_stall_cnt <= lu_stall_cnt + 32'd1;
      end
      if (mem_hold) begin
        mem_stall_cnt <= mem_stall_cnt + 32'd1;
      end
    end
  end
`else
  logic unused_perf;
  assign unused_perf = lu_act ^ mem_hold;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb/tb_pipeline_stall_ctrl.sv - directed + random check of pipeline_stall_ctrl against a behavioural model
module tb_pipeline_stall_ctrl;
  localparam int FC = 3;
  localparam int ST = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hz_load_use, branch_taken, dmem_busy;
  logic        pc_en, if_id_en, if_id_flush, id_ex_bubble, ex_mem_en, timeout;
  logic [1:0]  ctrl_state;
  logic [4:0]  outs;
`ifdef STALL_PERF_CNT_EN
  logic [31:0] lu_stall_cnt, mem_stall_cnt;
`endif

  pipeline_stall_ctrl #(.FLUSH_CYCLES(FC), .STALL_TIMEOUT(ST)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .hz_load_use  (hz_load_use),
    .branch_taken (branch_taken),
    .dmem_busy    (dmem_busy),
    .pc_en        (pc_en),
    .if_id_en     (if_id_en),
    .if_id_flush  (if_id_flush),
    .id_ex_bubble (id_ex_bubble),
    .ex_mem_en    (ex_mem_en),
    .ctrl_state   (ctrl_state),
    .timeout      (timeout)
`ifdef STALL_PERF_CNT_EN
    ,
    .lu_stall_cnt (lu_stall_cnt),
    .mem_stall_cnt(mem_stall_cnt)
`endif
  );

  assign outs = {pc_en, if_id_en, if_id_flush, id_ex_bubble, ex_mem_en};

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: remaining flush cycles, a "waiting on memory" flag, a stall run length.
  int          m_flush_left;
  bit          m_wait;
  int          m_stall;
  bit          m_to;
  logic [31:0] m_lu, m_mem;

  function automatic void model_reset();
    m_flush_left = 0;
    m_wait       = 0;
    m_stall      = 0;
    m_to         = 0;
    m_lu         = 0;
    m_mem        = 0;
  endfunction

  // Bit order: {pc_en, if_id_en, if_id_flush, id_ex_bubble, ex_mem_en}
  function automatic logic [4:0] model_outs(input bit b, input bit t, input bit h);
    if (b) return 5'b00000;
    if (t || m_flush_left > 0) return 5'b11111;
    if (h) return 5'b00011;
    return 5'b11001;
  endfunction

  function automatic logic [1:0] model_state();
    if (m_flush_left > 0) return 2'd2;
    if (m_wait) return 2'd1;
    return 2'd0;
  endfunction

  task automatic step(input bit b, input bit t, input bit h);
    logic [4:0] eo;
    @(negedge clk);
    dmem_busy = b; branch_taken = t; hz_load_use = h;
    #1;
    eo = model_outs(b, t, h);
    check("outs", 32'(outs), 32'(eo));
    check("ctrl_state", 32'(ctrl_state), 32'(model_state()));
    check("timeout", 32'(timeout), 32'(m_to));
`ifdef STALL_PERF_CNT_EN
    check("lu_stall_cnt", lu_stall_cnt, m_lu);
    check("mem_stall_cnt", mem_stall_cnt, m_mem);
`endif
    @(posedge clk);
    if (b) begin
      if (m_flush_left == 0) m_wait = 1;
      m_mem++;
    end else if (t) begin
      m_flush_left = FC - 1;
      m_wait = 0;
    end else if (m_flush_left > 0) begin
      m_flush_left--;
      m_wait = 0;
    end else begin
      m_wait = 0;
      if (h) m_lu++;
    end
    if (!eo[4]) begin
      m_stall = (m_stall + 1 > ST) ? ST : m_stall + 1;
      if (m_stall == ST) m_to = 1;
    end else begin
      m_stall = 0;
    end
  endtask

  task automatic check_in_reset(input string tag);
    check({tag, "_outs"}, 32'(outs), 32'd0);
    check({tag, "_state"}, 32'(ctrl_state), 32'd0);
    check({tag, "_timeout"}, 32'(timeout), 32'd0);
`ifdef STALL_PERF_CNT_EN
    check({tag, "_lu"}, lu_stall_cnt, 32'd0);
    check({tag, "_mem"}, mem_stall_cnt, 32'd0);
`endif
  endtask

  task automatic pulse_reset(input int cycles);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_in_reset("rst_async");
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      dmem_busy = 1'($urandom); branch_taken = 1'($urandom); hz_load_use = 1'($urandom);
      #1;
      check_in_reset("rst_hold");
    end
    @(negedge clk);
    dmem_busy = 0; branch_taken = 0; hz_load_use = 0;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    rst_n = 1'b0; dmem_busy = 0; branch_taken = 0; hz_load_use = 0;
    model_reset();
    #1;
    check_in_reset("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // load-use single cycle
    step(0, 0, 1);
    step(0, 0, 0);
    // branch with three-cycle flush
    step(0, 1, 0);
    repeat (3) step(0, 0, 0);
    // memory hold masks branch and load-use, branch acted on afterwards
    repeat (4) step(1, 1, 1);
    step(0, 1, 0);
    repeat (3) step(0, 0, 0);
    // branch inside a flush reloads it; busy inside a flush freezes it
    step(0, 1, 0);
    step(0, 0, 0);
    step(0, 1, 1);
    step(1, 0, 0);
    step(1, 1, 0);
    repeat (3) step(0, 0, 1);
    // watchdog: long memory stall, flag sticky afterwards
    repeat (10) step(1, 0, 0);
    repeat (4) step(0, 0, 0);
    // reset mid-flush
    step(0, 1, 0);
    pulse_reset(2);
    repeat (2) step(0, 0, 0);
    // reset mid-stall, no replay
    repeat (2) step(1, 1, 1);
    pulse_reset(1);
    step(0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        pulse_reset($urandom_range(0, 2));
      end else begin
        step($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 25);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pipeline_stall_ctrl.md
PIPELINE_STALL_CTRL -- requirements
Module: pipeline_stall_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 1, branch flush length in cycles (legal 1..15).
REQ-002 SHALL have parameter STALL_TIMEOUT, default 255, consecutive PC-stall cycles before watchdog (legal 1..255).
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port hz_load_use  input  1  load-use stall request from ID-stage hazard detection.
REQ-006 SHALL have port branch_taken  input  1  branch/jump resolved taken this cycle.
REQ-007 SHALL have port dmem_busy  input  1  data memory not ready; whole pipeline must hold.
REQ-008 SHALL have port pc_en  output  1  PC register load enable.
REQ-009 SHALL have port if_id_en  output  1  IF/ID register load enable.
REQ-010 SHALL have port if_id_flush  output  1  IF/ID register loads NOP.
REQ-011 SHALL have port id_ex_bubble  output  1  ID/EX control fields zeroed (bubble).
REQ-012 SHALL have port ex_mem_en  output  1  EX/MEM and MEM/WB load enable.
REQ-013 SHALL have port ctrl_state  output  2  current FSM state encoding.
REQ-014 SHALL have port timeout  output  1  sticky watchdog flag.

Function
REQ-015 SHALL implement FSM states RUN=2'd0, MEM_WAIT=2'd1, FLUSH=2'd2; 2'd3 SHALL transition to RUN next cycle with RUN outputs.
REQ-016 SHALL produce outputs combinationally from state and current inputs (zero-cycle latency); state/counters update on clk rising edge.
REQ-017 SHALL use request priority dmem_busy > branch_taken > hz_load_use in every state.
REQ-018 RUN, no request: pc_en=if_id_en=ex_mem_en=1, if_id_flush=id_ex_bubble=0, stay RUN.
REQ-019 RUN, dmem_busy=1: pc_en=if_id_en=ex_mem_en=0, flush/bubble=0; next MEM_WAIT.
REQ-020 RUN, branch_taken=1: pc_en=if_id_en=ex_mem_en=1, if_id_flush=id_ex_bubble=1; next FLUSH with flush_cnt=FLUSH_CYCLES-1 if FLUSH_CYCLES>1, else RUN.
REQ-021 RUN, hz_load_use=1 only: pc_en=if_id_en=0, id_ex_bubble=1, ex_mem_en=1, if_id_flush=0; stay RUN.
REQ-022 MEM_WAIT with dmem_busy=1: hold all (as REQ-019), ignore branch_taken/hz_load_use.
REQ-023 MEM_WAIT with dmem_busy=0: outputs and next state identical to RUN decision (REQ-018..021) in the same cycle.
REQ-024 FLUSH, dmem_busy=0: pc_en=if_id_en=ex_mem_en=1, if_id_flush=id_ex_bubble=1, flush_cnt decrements; at flush_cnt=0 after decrement -> RUN.
REQ-025 FLUSH, dmem_busy=1: hold all (REQ-019 outputs), flush_cnt frozen, stay FLUSH.
REQ-026 FLUSH, new branch_taken=1 with dmem_busy=0: reload flush_cnt=FLUSH_CYCLES-1, stay FLUSH (RUN if FLUSH_CYCLES=1).
REQ-027 SHALL keep 8-bit stall_cnt: +1 each cycle pc_en=0, cleared when pc_en=1, saturating at STALL_TIMEOUT.
REQ-028 SHALL set timeout on the edge stall_cnt reaches STALL_TIMEOUT; timeout SHALL remain 1 until reset and not alter pipeline control.

Reset
REQ-029 rst_n=0 SHALL immediately force state RUN, flush_cnt=0, stall_cnt=0, timeout=0, ctrl_state=2'd0.
REQ-030 While rst_n=0 SHALL drive pc_en=if_id_en=ex_mem_en=0, if_id_flush=id_ex_bubble=0, regardless of inputs.
REQ-031 Reset deassertion mid-stall SHALL resume from RUN with no replay of prior requests.

Configuration
REQ-032 Macro STALL_PERF_CNT_EN defined: SHALL add outputs lu_stall_cnt[31:0] (cycles with REQ-021 action) and mem_stall_cnt[31:0] (cycles with dmem_busy hold), wrapping modulo 2^32, reset to 0.
REQ-033 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-034 Reset, then hz_load_use=1 one cycle -> that cycle pc_en=0, if_id_en=0, id_ex_bubble=1; next cycle all enables 1, state 0.
REQ-035 FLUSH_CYCLES=3, branch_taken=1 one cycle -> if_id_flush=1 for exactly 3 consecutive cycles, ctrl_state 0,2,2,0.
REQ-036 dmem_busy=1 for 4 cycles with branch_taken and hz_load_use=1 -> pc_en=ex_mem_en=0 all 4 cycles, no flush; branch acted on when dmem_busy falls.
REQ-037 STALL_TIMEOUT=5, dmem_busy held 10 cycles -> timeout rises after 5th stall edge, stays 1 after dmem_busy=0 until rst_n pulse.
REQ-038 rst_n pulsed low mid-FLUSH -> outputs immediately per REQ-030; after release state 0 with flush=0; with STALL_PERF_CNT_EN, counters read 0.
